// File: rtl/ms_jk_reg_bank.sv
// ms_jk_reg_bank: master-slave JK/SR/D/T register bank with sticky SR-forbidden flags
// and a saturating count of cycles in which the master state changed.
module ms_jk_reg_bank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 MS_STAGE  = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] sr_err,
    output logic [CNT_W-1:0] chg_cnt
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [WIDTH-1:0] m, upd, m_next, q_next, err_set;
    logic             changed;
    always_comb begin
        upd = mode == 2'b00 ? (j & ~m) | (~k & m) :
              mode == 2'b01 ? (j & ~k) | (m & ~(k & ~j)) :
              mode == 2'b10 ? j : m ^ j;
        m_next  = load ? load_val : en ? upd : m;
        err_set = (en && !load && mode == 2'b01) ? (j & k) : '0;
        changed = m_next != m;
        q_next  = (MS_STAGE != 0) ? m : m_next;
    end
    // Reset forces q directly so no stale master value is ever visible afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m       <= RESET_VAL;
            q       <= RESET_VAL;
            qbar    <= ~RESET_VAL;
            sr_err  <= '0;
            chg_cnt <= '0;
        end else begin
            m       <= m_next;
            q       <= q_next;
            qbar    <= ~q_next;
            sr_err  <= (err_clr ? '0 : sr_err) | err_set;
            chg_cnt <= cnt_clr ? (changed ? ONE : '0) :
                       (changed && !(&chg_cnt)) ? chg_cnt + ONE : chg_cnt;
        end
    end
endmodule

// File: tb/tb_ms_jk_reg_bank.sv
// tb_ms_jk_reg_bank: directed checks on a master-slave instance (CNT_W=4, RESET_VAL=A5)
// and a transparent instance (MS_STAGE=0) driven by the same stimulus.
module tb_ms_jk_reg_bank;
    logic       clk = 1'b0;
    logic       rst, en, load, err_clr, cnt_clr;
    logic [1:0] mode;
    logic [7:0] j, k, load_val;
    logic [7:0] qa, qbara, erra, qb, qbarb, errb;
    logic [3:0]  cnta;
    logic [15:0] cntb;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ms_jk_reg_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .MS_STAGE(1), .CNT_W(4)) da (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .load(load),
        .load_val(load_val), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .q(qa), .qbar(qbara), .sr_err(erra), .chg_cnt(cnta));

    ms_jk_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00), .MS_STAGE(0), .CNT_W(16)) db (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .load(load),
        .load_val(load_val), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .q(qb), .qbar(qbarb), .sr_err(errb), .chg_cnt(cntb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 0; en = 0; load = 0; err_clr = 0; cnt_clr = 0;
        mode = 2'b00; j = 0; k = 0; load_val = 0;
        tick(); tick();
        chk("rst_qa", qa, 8'hA5);
        chk("rst_qbara", qbara, 8'h5A);
        chk("rst_erra", erra, 0);
        chk("rst_cnta", cnta, 0);
        chk("rst_qb", qb, 8'h00);
        chk("rst_qbarb", qbarb, 8'hFF);
        rst = 1;
        // JK toggle from m=00
        load = 1; load_val = 8'h00; tick();
        chk("ld0_qa", qa, 8'hA5);
        chk("ld0_qb", qb, 8'h00);
        chk("ld0_cnta", cnta, 1);
        load = 0; cnt_clr = 1; tick();
        chk("clr_cnta", cnta, 0);
        chk("clr_qa", qa, 8'h00);
        cnt_clr = 0; en = 1; mode = 2'b00; j = 8'hFF; k = 8'hFF;
        tick();
        chk("tg1_qa", qa, 8'h00);
        chk("tg1_qb", qb, 8'hFF);
        tick();
        chk("tg2_qa", qa, 8'hFF);
        chk("tg2_qb", qb, 8'h00);
        tick();
        chk("tg3_qa", qa, 8'h00);
        chk("tg3_qbarb", qbarb, 8'h00);
        en = 0; tick();
        chk("tg4_qa", qa, 8'hFF);
        chk("tg_cnta", cnta, 3);
        chk("tg_cntb", cntb, 3);
        // SR forbidden combination on bits [1:0]
        load = 1; load_val = 8'h00; tick();
        load = 0; en = 1; mode = 2'b01; j = 8'h0F; k = 8'h03; tick();
        chk("sr_qb", qb, 8'h0C);
        chk("sr_erra", erra, 8'h03);
        chk("sr_errb", errb, 8'h03);
        chk("sr_cnta", cnta, 5);
        err_clr = 1; tick();
        chk("sr_errwin", erra, 8'h03);
        chk("sr_hold_qa", qa, 8'h0C);
        en = 0; j = 0; k = 0; tick();
        chk("sr_clr", erra, 8'h00);
        err_clr = 0;
        // load beats en
        load = 1; load_val = 8'h3C; en = 1; mode = 2'b00; j = 8'hFF; k = 8'hFF; tick();
        chk("ld_qb", qb, 8'h3C);
        chk("ld_qa_lag", qa, 8'h0C);
        chk("ld_cnta", cnta, 6);
        load = 0; en = 0; tick();
        chk("ld_qa", qa, 8'h3C);
        chk("ld_qbara", qbara, 8'hC3);
        // counter saturation in T mode
        cnt_clr = 1; tick();
        cnt_clr = 0; en = 1; mode = 2'b11; j = 8'h01; k = 8'h00;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnta", cnta, 15);
        chk("sat_cntb", cntb, 20);
        chk("sat_qb", qb, 8'h3C);
        cnt_clr = 1; tick();
        chk("clrchg_cnta", cnta, 1);
        chk("clrchg_cntb", cntb, 1);
        chk("clrchg_qb", qb, 8'h3D);
        chk("clrchg_qa", qa, 8'h3C);
        cnt_clr = 0; tick();
        chk("pre_rst_qa", qa, 8'h3D);
        chk("pre_rst_cnta", cnta, 2);
        // reset while toggling
        rst = 0; tick();
        chk("mid_rst_qa", qa, 8'hA5);
        chk("mid_rst_qbara", qbara, 8'h5A);
        chk("mid_rst_cnta", cnta, 0);
        chk("mid_rst_qb", qb, 8'h00);
        rst = 1; tick();
        chk("post_qa", qa, 8'hA5);
        chk("post_qb", qb, 8'h01);
        chk("post_cntb", cntb, 1);
        tick();
        chk("post2_qa", qa, 8'hA4);
        chk("post2_cnta", cnta, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
